// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, NR async read ports, one sync write port.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int B  = 32,
  parameter int W  = 5,
  parameter int NR = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [W-1:0]    w_addr,
  input  logic [B-1:0]    w_data,
  input  logic [NR*W-1:0] r_addr,
  output logic [NR*B-1:0] r_data,
  input  logic            rsv_en,
  input  logic [W-1:0]    rsv_addr,
  output logic [NR-1:0]   busy,
  output logic [W:0]      pend_cnt
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0]     regs_reg [DEPTH];
  logic [DEPTH-1:0] pend_reg;
  logic [DEPTH-1:0] pend_next;
  logic [W:0]       pend_cnt_reg;
  logic [W:0]       pend_cnt_next;

  logic wr_hit;
  logic rsv_hit;
  logic set_inc;
  logic clr_dec;

  assign wr_hit  = wr_en && (w_addr != '0);
  assign rsv_hit = rsv_en && (rsv_addr != '0);

  // A reserve to the register being written wins: the younger producer keeps it pending.
  always_comb begin
    set_inc   = rsv_hit && !pend_reg[rsv_addr];
    clr_dec   = wr_hit && pend_reg[w_addr] && !(rsv_hit && (rsv_addr == w_addr));
    pend_next = pend_reg;
    if (wr_hit) pend_next[w_addr] = 1'b0;
    if (rsv_hit) pend_next[rsv_addr] = 1'b1;
    pend_cnt_next = pend_cnt_reg + (W+1)'(set_inc) - (W+1)'(clr_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      pend_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      if (wr_hit) regs_reg[w_addr] <= w_data;
      pend_reg     <= pend_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt = pend_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rd
      logic [W-1:0] addr;
      assign addr = r_addr[gi*W +: W];
`ifdef REGFILE_BYPASS_EN
      logic byp;
      logic keep_busy;
      assign byp       = wr_hit && (w_addr == addr);
      assign keep_busy = rsv_hit && (rsv_addr == addr);
      assign r_data[gi*B +: B] = (addr == '0) ? '0 : (byp ? w_data : regs_reg[addr]);
      assign busy[gi] = (addr != '0) && pend_reg[addr] && (!byp || keep_busy);
`else
      assign r_data[gi*B +: B] = (addr == '0) ? '0 : regs_reg[addr];
      assign busy[gi] = (addr != '0) && pend_reg[addr];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed vector table for the scoreboard corner cases, then random traffic vs a model.
module tb_regfile_scoreboard;

  localparam int B  = 32;
  localparam int W  = 5;
  localparam int NR = 2;
  localparam int DEPTH = 1 << W;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [W-1:0]    w_addr;
  logic [B-1:0]    w_data;
  logic [NR*W-1:0] r_addr;
  logic [NR*B-1:0] r_data;
  logic            rsv_en;
  logic [W-1:0]    rsv_addr;
  logic [NR-1:0]   busy;
  logic [W:0]      pend_cnt;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard #(.B(B), .W(W), .NR(NR)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr), .r_data(r_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(busy), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         wr;
    logic [W-1:0] wa;
    logic [B-1:0] wd;
    logic         rsv;
    logic [W-1:0] ra;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [B-1:0] d0;
    logic [B-1:0] d1;
    logic [1:0]   bsy;
    logic [W:0]   cnt;
  } vec_t;

  vec_t vecs[$];

  // behavioural reference: plain arrays updated by the rules for each edge
  logic [B-1:0] m_mem [DEPTH];
  bit           m_pend[DEPTH];

  task automatic chk(input string nm, input logic [B-1:0] got, input logic [B-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [W-1:0] wa, input logic [B-1:0] wd,
                       input logic rsv, input logic [W-1:0] ra, input logic [W-1:0] a0, input logic [W-1:0] a1);
    reset = rst; wr_en = wr; w_addr = wa; w_data = wd;
    rsv_en = rsv; rsv_addr = ra; r_addr = {a1, a0};
  endtask

  function automatic vec_t mk(logic rst, logic wr, logic [W-1:0] wa, logic [B-1:0] wd, logic rsv,
                              logic [W-1:0] ra, logic [W-1:0] a0, logic [W-1:0] a1,
                              logic [B-1:0] d0, logic [B-1:0] d1, logic [1:0] bsy, logic [W:0] cnt);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wa = wa; v.wd = wd; v.rsv = rsv; v.ra = ra;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.bsy = bsy; v.cnt = cnt;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) model_reset();
    else begin
      if (wr_en && w_addr != 0) begin
        m_mem[w_addr]  = w_data;
        m_pend[w_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  initial begin
    int n;
    int cnt_exp;
    logic [W-1:0] a;
    logic [B-1:0] d_exp;
    logic b_exp;
    bit hit;

    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // post-reset sweep of every address on both ports
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = {W'(i), W'(DEPTH - 1 - i)};
      #1;
      chk($sformatf("reset_rd0_a%0d", DEPTH - 1 - i), r_data[B-1:0], '0);
      chk($sformatf("reset_rd1_a%0d", i), r_data[2*B-1:B], '0);
      chk($sformatf("reset_busy_a%0d", i), B'(busy), '0);
    end
    chk("reset_cnt", B'(pend_cnt), '0);

    //        rst wr wa  wd            rsv ra  a0 a1  d0                                d1                  bsy                        cnt
    vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1234,     0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 7, 5, 7, 32'hDEADBEEF, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 1, 7, 32'h55,       0, 0, 5, 7, 32'hDEADBEEF, BYP ? 32'h55 : 32'h0, BYP ? 2'b00 : 2'b10, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 5, 7, 32'hDEADBEEF, 32'h55, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 3, 3, 4, 32'h0, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 4, 3, 4, 32'h0, 32'h0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 3, 32'hAA,       1, 3, 3, 4, BYP ? 32'hAA : 32'h0, 32'h0, 2'b11, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 3, 4, 32'hAA, 32'h0, 2'b11, 2));
    vecs.push_back(mk(0, 1, 3, 32'h33,       0, 0, 3, 4, BYP ? 32'h33 : 32'hAA, 32'h0, BYP ? 2'b10 : 2'b11, 2));
    vecs.push_back(mk(0, 1, 4, 32'h44,       0, 0, 3, 4, 32'h33, BYP ? 32'h44 : 32'h0, BYP ? 2'b00 : 2'b10, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 9, 9, 0, 32'h0, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 9, 9, 0, 32'h0, 32'h0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 9, 0, 32'h0, 32'h0, 2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 9, 0, 32'h0, 32'h0, 2'b01, 1));
    vecs.push_back(mk(0, 1, 9, 32'h99,       0, 0, 9, 0, BYP ? 32'h99 : 32'h0, 32'h0, BYP ? 2'b00 : 2'b01, 1));
    vecs.push_back(mk(0, 1, 2, 32'h77,       0, 0, 2, 0, BYP ? 32'h77 : 32'h0, 32'h0, 2'b00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 2, 2, 0, 32'h77, 32'h0, 2'b00, 0));
    vecs.push_back(mk(1, 1, 2, 32'hFF,       0, 0, 2, 0, BYP ? 32'hFF : 32'h77, 32'h0, BYP ? 2'b00 : 2'b01, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 2, 7, 32'h0, 32'h0, 2'b00, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].ra, vecs[i].a0, vecs[i].a1);
      @(negedge clk);
      $display("vec %0d: a0=%0d a1=%0d d0=%h d1=%h busy=%b cnt=%0d", i, vecs[i].a0, vecs[i].a1,
               r_data[B-1:0], r_data[2*B-1:B], busy, pend_cnt);
      chk($sformatf("vec%0d_d0", i), r_data[B-1:0], vecs[i].d0);
      chk($sformatf("vec%0d_d1", i), r_data[2*B-1:B], vecs[i].d1);
      chk($sformatf("vec%0d_busy", i), B'(busy), B'(vecs[i].bsy));
      chk($sformatf("vec%0d_cnt", i), B'(pend_cnt), B'(vecs[i].cnt));
      @(posedge clk);
      #1;
    end

    // random traffic over a narrow address window so collisions are frequent
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)),
            W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
      @(negedge clk);
      n = 0;
      for (int p = 0; p < NR; p++) begin
        a = r_addr[p*W +: W];
        hit = BYP && wr_en && (w_addr != 0) && (w_addr == a);
        d_exp = (a == 0) ? '0 : (hit ? w_data : m_mem[a]);
        b_exp = (a != 0) && m_pend[a] && !(hit && !(rsv_en && rsv_addr == a));
        chk($sformatf("rnd%0d_d%0d", c, p), r_data[p*B +: B], d_exp);
        chk($sformatf("rnd%0d_busy%0d", c, p), B'(busy[p]), B'(b_exp));
      end
      cnt_exp = 0;
      for (int i = 0; i < DEPTH; i++) cnt_exp += int'(m_pend[i]);
      chk($sformatf("rnd%0d_cnt", c), B'(pend_cnt), B'(cnt_exp));
      n = cnt_exp;
      $display("rnd %0d: rst=%0b wr=%0b/%0d rsv=%0b/%0d busy=%b cnt=%0d", c, reset, wr_en, w_addr,
               rsv_en, rsv_addr, busy, n);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
